spi_cmd_decoder: RTL and testbench

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/synthyboy_pkg.sv | 37 +++
 rtl/cmd_timeout.sv | 29 ++
 rtl/spi_cmd_decoder.sv | 147 ++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/synthyboy_pkg.sv
// Shared definitions for the synth SPI command path: FSM states, register
// codes, oscillator codes and the register-to-payload-length table.
package synthyboy_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } cmd_state_t;

    typedef enum logic [3:0] {
        REG_NONE  = 4'h0,
        REG_WAVE  = 4'h1,
        REG_FREQ  = 4'h2,
        REG_PHASE = 4'h3,
        REG_AMP   = 4'h4
    } reg_code_t;

    localparam logic [3:0] OSC1_CODE = 4'h0;
    localparam logic [3:0] OSC2_CODE = 4'h1;

    // Zero length marks a register code that does not exist.
    function automatic logic [1:0] payload_len(input logic [3:0] code);
        case (code)
            REG_WAVE:  return 2'd1;
            REG_FREQ:  return 2'd3;
            REG_PHASE: return 2'd2;
            REG_AMP:   return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return ((cmd[7:4] == OSC1_CODE) || (cmd[7:4] == OSC2_CODE)) &&
               (payload_len(cmd[3:0]) != 2'd0);
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Idle-gap watchdog: counts cycles while enabled and flags the cycle on
// which the gap reaches TIMEOUT_CYCLES without a clear.
module cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || !i_enable) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + W'(1);
        end
    end

    // A byte on the same cycle clears the counter, so it always beats expiry.
    assign o_expired = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command bytes into per-oscillator wave/freq/phase/amp
// registers; payloads arrive LSB first and commit atomically.
module spi_cmd_decoder
    import synthyboy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        i_clk50mhz,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [7:0]  o_osc1_wave,
    output logic [7:0]  o_osc2_wave,
    output logic [23:0] o_osc1_freq,
    output logic [23:0] o_osc2_freq,
    output logic [15:0] o_osc1_phase,
    output logic [15:0] o_osc2_phase,
    output logic [15:0] o_osc1_amp,
    output logic [15:0] o_osc2_amp,
    output logic [1:0]  o_update,
    output logic        o_busy,
    output logic        o_timeout
);

    cmd_state_t  r_state;
    reg_code_t   r_reg;
    logic        r_osc;
    logic [1:0]  r_len;
    logic [1:0]  r_count;
    logic [23:0] r_shadow;
    logic [7:0]  r_osc1_wave, r_osc2_wave;
    logic [23:0] r_osc1_freq, r_osc2_freq;
    logic [15:0] r_osc1_phase, r_osc2_phase;
    logic [15:0] r_osc1_amp, r_osc2_amp;
    logic [1:0]  r_update;
    logic        r_timeout;

    logic [23:0] w_next_shadow;
    logic        w_last;
    logic        w_expired;
    logic        w_in_payload;

    assign w_in_payload = (r_state == ST_PAYLOAD);

    cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk50mhz),
        .i_rst     (i_rst),
        .i_clear   (i_byte_valid),
        .i_enable  (w_in_payload),
        .o_expired (w_expired)
    );

    // Byte n of the payload lands in lane n, giving LSB-first assembly.
    always_comb begin
        w_next_shadow = r_shadow;
        w_next_shadow[{r_count, 3'b000} +: 8] = i_byte;
    end

    assign w_last = ((r_count + 2'd1) == r_len);

    always_ff @(posedge i_clk50mhz) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_reg        <= REG_NONE;
            r_osc        <= 1'b0;
            r_len        <= '0;
            r_count      <= '0;
            r_shadow     <= '0;
            r_osc1_wave  <= '0;
            r_osc2_wave  <= '0;
            r_osc1_freq  <= '0;
            r_osc2_freq  <= '0;
            r_osc1_phase <= '0;
            r_osc2_phase <= '0;
            r_osc1_amp   <= '0;
            r_osc2_amp   <= '0;
            r_update     <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_update  <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_byte_valid && is_valid_cmd(i_byte)) begin
                        r_osc    <= (i_byte[7:4] == OSC2_CODE);
                        r_reg    <= reg_code_t'(i_byte[3:0]);
                        r_len    <= payload_len(i_byte[3:0]);
                        r_count  <= '0;
                        r_shadow <= '0;
                        r_state  <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (i_byte_valid) begin
                        r_shadow <= w_next_shadow;
                        r_count  <= r_count + 2'd1;
                        if (w_last) begin
                            r_state  <= ST_IDLE;
                            r_shadow <= '0;
                            r_update <= r_osc ? 2'b10 : 2'b01;
                            case (r_reg)
                                REG_WAVE: begin
                                    if (r_osc) r_osc2_wave <= w_next_shadow[7:0];
                                    else       r_osc1_wave <= w_next_shadow[7:0];
                                end
                                REG_FREQ: begin
                                    if (r_osc) r_osc2_freq <= w_next_shadow;
                                    else       r_osc1_freq <= w_next_shadow;
                                end
                                REG_PHASE: begin
                                    if (r_osc) r_osc2_phase <= w_next_shadow[15:0];
                                    else       r_osc1_phase <= w_next_shadow[15:0];
                                end
                                REG_AMP: begin
                                    if (r_osc) r_osc2_amp <= w_next_shadow[15:0];
                                    else       r_osc1_amp <= w_next_shadow[15:0];
                                end
                                default: ;
                            endcase
                        end
                    end else if (w_expired) begin
                        r_state   <= ST_IDLE;
                        r_shadow  <= '0;
                        r_count   <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_osc1_wave  = r_osc1_wave;
    assign o_osc2_wave  = r_osc2_wave;
    assign o_osc1_freq  = r_osc1_freq;
    assign o_osc2_freq  = r_osc2_freq;
    assign o_osc1_phase = r_osc1_phase;
    assign o_osc2_phase = r_osc2_phase;
    assign o_osc1_amp   = r_osc1_amp;
    assign o_osc2_amp   = r_osc2_amp;
    assign o_update     = r_update;
    assign o_busy       = w_in_payload;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed command sequences plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_spi_cmd_decoder;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  inByte = '0;
    logic        inValid = 1'b0;
    logic [7:0]  osc1Wave, osc2Wave;
    logic [23:0] osc1Freq, osc2Freq;
    logic [15:0] osc1Phase, osc2Phase;
    logic [15:0] osc1Amp, osc2Amp;
    logic [1:0]  update;
    logic        busy;
    logic        timeoutPulse;

    int nChecks = 0;
    int nBad = 0;

    // Model state: per-oscillator register values and the command in flight.
    logic [31:0] expWave[2], expFreq[2], expPhase[2], expAmp[2];
    logic [31:0] expUpdate, expTimeout, expBusy;
    bit          mInCmd;
    int          mOsc, mReg, mNeed, mIdle;
    byte unsigned mData[$];

    spi_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk50mhz   (clk),
        .i_rst        (rst),
        .i_byte       (inByte),
        .i_byte_valid (inValid),
        .o_osc1_wave  (osc1Wave),
        .o_osc2_wave  (osc2Wave),
        .o_osc1_freq  (osc1Freq),
        .o_osc2_freq  (osc2Freq),
        .o_osc1_phase (osc1Phase),
        .o_osc2_phase (osc2Phase),
        .o_osc1_amp   (osc1Amp),
        .o_osc2_amp   (osc2Amp),
        .o_update     (update),
        .o_busy       (busy),
        .o_timeout    (timeoutPulse)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model of one clock edge, phrased as byte-stream rules, not FSM states.
    task automatic modelStep(input bit r, input bit v, input logic [7:0] b);
        int value;
        int hi, lo;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                expWave[i] = 0; expFreq[i] = 0; expPhase[i] = 0; expAmp[i] = 0;
            end
            expUpdate = 0; expTimeout = 0; expBusy = 0;
            mInCmd = 0; mIdle = 0; mData.delete();
            return;
        end
        expUpdate = 0;
        expTimeout = 0;
        hi = int'(b) / 16;
        lo = int'(b) % 16;
        if (!mInCmd) begin
            if (v && hi <= 1 && lo >= 1 && lo <= 4) begin
                mInCmd = 1;
                mOsc = hi;
                mReg = lo;
                mNeed = (lo == 1) ? 1 : (lo == 2) ? 3 : 2;
                mData.delete();
                mIdle = 0;
            end
        end else if (v) begin
            mData.push_back(b);
            mIdle = 0;
            if (mData.size() == mNeed) begin
                value = 0;
                foreach (mData[i]) value += int'(mData[i]) * (1 << (8 * i));
                case (mReg)
                    1: expWave[mOsc]  = value % 256;
                    2: expFreq[mOsc]  = value;
                    3: expPhase[mOsc] = value % 65536;
                    default: expAmp[mOsc] = value % 65536;
                endcase
                expUpdate = (mOsc == 0) ? 1 : 2;
                mInCmd = 0;
            end
        end else begin
            mIdle++;
            if (mIdle == T) begin
                expTimeout = 1;
                mInCmd = 0;
            end
        end
        expBusy = mInCmd ? 1 : 0;
    endtask

    task automatic checkAll();
        checkOutput("update", 32'(update), expUpdate);
        checkOutput("busy", 32'(busy), expBusy);
        checkOutput("timeout", 32'(timeoutPulse), expTimeout);
        checkOutput("osc1_wave", 32'(osc1Wave), expWave[0]);
        checkOutput("osc2_wave", 32'(osc2Wave), expWave[1]);
        checkOutput("osc1_freq", 32'(osc1Freq), expFreq[0]);
        checkOutput("osc2_freq", 32'(osc2Freq), expFreq[1]);
        checkOutput("osc1_phase", 32'(osc1Phase), expPhase[0]);
        checkOutput("osc2_phase", 32'(osc2Phase), expPhase[1]);
        checkOutput("osc1_amp", 32'(osc1Amp), expAmp[0]);
        checkOutput("osc2_amp", 32'(osc2Amp), expAmp[1]);
    endtask

    // One cycle: drive at the falling edge, model the rising edge, check at the next fall.
    task automatic applyStimulus(input bit r, input bit v, input logic [7:0] b);
        rst = r;
        inValid = v;
        inByte = b;
        @(posedge clk);
        modelStep(r, v, b);
        @(negedge clk);
        checkAll();
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, b);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] cmd;
        int nPay;
        int gapSel;

        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        idleCycles(2);

        sendByte(8'h01); sendByte(8'h05); sendByte(8'h00);
        idleCycles(2);

        sendByte(8'h02); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h00);
        sendByte(8'h02); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h03);
        idleCycles(1);

        sendByte(8'h14); sendByte(8'hFF); sendByte(8'h7F);
        idleCycles(1);

        sendByte(8'h04); sendByte(8'hFF);
        idleCycles(T + 2);
        sendByte(8'h04); sendByte(8'h34); sendByte(8'h12);
        idleCycles(1);

        // Byte arriving on the last permitted idle cycle must still be taken.
        sendByte(8'h13); sendByte(8'h11);
        idleCycles(T - 1);
        sendByte(8'h22);
        idleCycles(1);

        sendByte(8'h07); sendByte(8'h2F); sendByte(8'h00);
        idleCycles(1);

        sendByte(8'h02); sendByte(8'hAA);
        applyStimulus(1'b1, 1'b0, 8'h00);
        idleCycles(3);

        // Back-to-back commands with no gap after a commit.
        sendByte(8'h01); sendByte(8'hAA); sendByte(8'h11); sendByte(8'hBB);
        idleCycles(1);

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 49) == 0) applyStimulus(1'b1, 1'b0, 8'h00);
            if ($urandom_range(0, 4) == 0)
                cmd = 8'($urandom_range(0, 255));
            else
                cmd = 8'(($urandom_range(0, 1) << 4) | $urandom_range(1, 4));
            sendByte(cmd);
            nPay = $urandom_range(0, 3);
            for (int p = 0; p < nPay; p++) begin
                gapSel = $urandom_range(0, 9);
                if (gapSel == 7)      idleCycles(T - 1);
                else if (gapSel == 8) idleCycles(T);
                else if (gapSel == 9) idleCycles($urandom_range(1, 4));
                sendByte(8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 1) == 0) idleCycles($urandom_range(0, 3));
        end
        idleCycles(T + 2);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
